// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: fetch PC owner plus in-order prefetch buffer
// that feeds IF/ID.
// Ports: clk, reset (sync, active-high); redirect_valid/redirect_pc from
// EX/MEM; stall from the hazard unit; imem_req/addr/gnt/rvalid/rdata to
// the pipelined I-memory; if_valid/if_pc/if_instr to IF/ID.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [63:0]      r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [DEPTH-1:0] r_filled;
  ptr_t             r_alloc;
  ptr_t             r_fill;
  ptr_t             r_head;
  cnt_t             r_occ;
  cnt_t             r_pend;
  cnt_t             r_drop;
  logic [63:0]      r_fetch_pc;

  logic             w_alloc;
  logic             w_fill;
  logic             w_drop;
  logic             w_pop;
  logic [CW:0]      w_sum;
  cnt_t             w_drop_redir;
  logic [DEPTH-1:0] w_filled_nxt;

  // Registered occupancy only: a pop this cycle does not open a slot.
  assign imem_req  = !reset && !redirect_valid
                   && (r_occ < cnt_t'(DEPTH));
  assign imem_addr = r_fetch_pc;

  assign w_alloc = imem_req && imem_gnt;
  assign w_drop  = imem_rvalid && (r_drop != '0);
  // A response with nothing pending and nothing to drop is ignored.
  assign w_fill  = imem_rvalid && (r_drop == '0)
                 && (r_pend != '0);

  assign if_valid = (r_occ != '0) && r_filled[r_head];
  assign if_pc    = if_valid ? r_pc[r_head] : '0;
  assign if_instr = if_valid ? r_instr[r_head] : '0;
  assign w_pop    = if_valid && !stall && !redirect_valid;

  // Responses still owed by the memory after a redirect: everything
  // pending plus what was already owed, less the one arriving now.
  always_comb begin
    w_sum = (CW+1)'(r_drop) + (CW+1)'(r_pend);
    if (imem_rvalid && (w_sum != '0)) begin
      w_sum = w_sum - (CW+1)'(1);
    end
    w_drop_redir = (w_sum > (CW+1)'(DEPTH))
                 ? cnt_t'(DEPTH) : cnt_t'(w_sum);
  end

  always_comb begin
    w_filled_nxt = r_filled;
    if (w_alloc) w_filled_nxt[r_alloc] = 1'b0;
    if (w_fill)  w_filled_nxt[r_fill]  = 1'b1;
    if (w_pop)   w_filled_nxt[r_head]  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alloc    <= '0;
      r_fill     <= '0;
      r_head     <= '0;
      r_occ      <= '0;
      r_pend     <= '0;
      r_drop     <= '0;
      r_filled   <= '0;
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_alloc    <= '0;
      r_fill     <= '0;
      r_head     <= '0;
      r_occ      <= '0;
      r_pend     <= '0;
      r_filled   <= '0;
      r_drop     <= w_drop_redir;
      r_fetch_pc <= {redirect_pc[63:2], 2'b00};
    end else begin
      r_filled <= w_filled_nxt;
      r_occ    <= r_occ + cnt_t'(w_alloc) - cnt_t'(w_pop);
      r_pend   <= r_pend + cnt_t'(w_alloc) - cnt_t'(w_fill);
      if (w_alloc) begin
        r_alloc    <= r_alloc + ptr_t'(1);
        r_fetch_pc <= r_fetch_pc + 64'd4;
      end
      if (w_fill) r_fill <= r_fill + ptr_t'(1);
      if (w_pop)  r_head <= r_head + ptr_t'(1);
      if (w_drop) r_drop <= r_drop - cnt_t'(1);
    end
  end

  // Payload storage; validity lives in r_occ/r_filled.
  always_ff @(posedge clk) begin
    if (w_alloc) r_pc[r_alloc]   <= r_fetch_pc;
    if (w_fill)  r_instr[r_fill] <= imem_rdata;
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: random + directed check of the prefetch queue
// against a queue-level reference model and an in-order memory model.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h0;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic        filled;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  ent_t        mdl[$];
  mreq_t       memq[$];
  logic [63:0] m_fpc;
  int          m_drop;
  bit          known;
  int          cyc;
  int          lat;
  int          n_vec;
  int          n_err;

  logic        s_req;
  logic [63:0] s_addr;
  logic        s_v;
  logic [63:0] s_pc;
  logic [31:0] s_instr;

  function automatic logic [31:0] memf(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input bit rst, input bit rdv,
                      input logic [63:0] rpc,
                      input bit stl, input bit gnt);
    logic        m_req;
    logic        m_v;
    logic [63:0] m_pc;
    logic [31:0] m_in;
    bit          pop;
    int          pend;
    int          d;
    int          due;
    reset          = rst;
    redirect_valid = rdv;
    redirect_pc    = rpc;
    stall          = stl;
    imem_gnt       = gnt;
    if (!rst && memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(memq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_v     = if_valid;
    s_pc    = if_pc;
    s_instr = if_instr;
    m_req = !rst && !rdv && (mdl.size() < DEPTH);
    m_v   = (mdl.size() > 0) && mdl[0].filled;
    m_pc  = m_v ? mdl[0].pc : 64'h0;
    m_in  = m_v ? mdl[0].data : 32'h0;
    if (known) begin
      check("imem_req", s_req, m_req);
      check("imem_addr", s_addr, m_fpc);
      check("if_valid", s_v, m_v);
      check("if_pc", s_pc, m_pc);
      check("if_instr", s_instr, m_in);
    end
    if (rst) begin
      mdl.delete();
      m_fpc  = RPC;
      m_drop = 0;
    end else if (rdv) begin
      pend = 0;
      foreach (mdl[i]) if (!mdl[i].filled) pend++;
      d = m_drop + pend;
      if (imem_rvalid && d > 0) d--;
      m_drop = (d > DEPTH) ? DEPTH : d;
      mdl.delete();
      m_fpc = {rpc[63:2], 2'b00};
    end else begin
      pop = m_v && !stl;
      if (imem_rvalid) begin
        if (m_drop > 0) m_drop--;
        else begin
          for (int i = 0; i < mdl.size(); i++) begin
            if (!mdl[i].filled) begin
              mdl[i].filled = 1'b1;
              mdl[i].data   = imem_rdata;
              break;
            end
          end
        end
      end
      if (pop) void'(mdl.pop_front());
      if (m_req && gnt) begin
        mdl.push_back('{pc: m_fpc, filled: 1'b0, data: 32'h0});
        m_fpc = m_fpc + 64'd4;
      end
    end
    if (rst) memq.delete();
    else begin
      if (imem_rvalid) void'(memq.pop_front());
      if (s_req && gnt) begin
        due = cyc + lat;
        if (memq.size() > 0 && memq[$].due > due) due = memq[$].due;
        memq.push_back('{addr: s_addr, due: due});
      end
    end
    if (rst) known = 1'b1;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_valid(input int bound);
    for (int i = 0; i < bound; i++) begin
      tick(0, 0, 64'h0, 0, 1);
      if (s_v) break;
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; lat = 1;
    known = 1'b0; m_fpc = RPC; m_drop = 0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    stall = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    @(negedge clk);

    // Streaming from reset with a 1-cycle memory, then a 6-cycle stall.
    tick(1, 0, 64'h0, 0, 1);
    tick(1, 0, 64'h0, 0, 1);
    check("rst_valid", s_v, 0);
    tick(0, 0, 64'h0, 0, 1);
    check("s1_addr0", s_addr, 64'h0);
    check("s1_v0", s_v, 0);
    tick(0, 0, 64'h0, 0, 1);
    check("s1_addr4", s_addr, 64'h4);
    tick(0, 0, 64'h0, 0, 1);
    check("s1_first_v", s_v, 1);
    check("s1_first_pc", s_pc, 64'h0);
    check("s1_first_in", s_instr, memf(64'h0));
    for (int i = 1; i <= 3; i++) begin
      tick(0, 0, 64'h0, 0, 1);
      check("s1_stream_pc", s_pc, 64'(4 * i));
    end
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 64'h0, 1, 1);
      check("stall_pc", s_pc, 64'h10);
      check("stall_in", s_instr, memf(64'h10));
      if (i == 1) check("stall_last_addr", s_addr, 64'h1C);
      if (i >= 2) check("stall_req_off", s_req, 0);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 64'h0, 0, 1);
      check("rel_v", s_v, 1);
      check("rel_pc", s_pc, 64'h10 + 64'(4 * i));
    end

    // Redirect with two responses in flight on a 3-cycle memory.
    tick(1, 0, 64'h0, 0, 1);
    lat = 3;
    tick(0, 0, 64'h0, 0, 1);
    tick(0, 0, 64'h0, 0, 1);
    tick(0, 1, 64'h200, 0, 1);
    run_until_valid(20);
    check("rd2_v", s_v, 1);
    check("rd2_pc", s_pc, 64'h200);
    check("rd2_in", s_instr, memf(64'h200));

    // Redirect coinciding with the only pending response, unaligned target.
    tick(1, 0, 64'h0, 0, 1);
    lat = 1;
    tick(0, 0, 64'h0, 0, 1);
    tick(0, 1, 64'h203, 0, 1);
    tick(0, 0, 64'h0, 0, 1);
    check("rd1_addr", s_addr, 64'h200);
    check("rd1_req", s_req, 1);
    run_until_valid(20);
    check("rd1_pc", s_pc, 64'h200);
    check("rd1_in", s_instr, memf(64'h200));

    // Reset while the queue holds filled entries from another stream.
    tick(0, 1, 64'h400, 0, 1);
    for (int i = 0; i < 5; i++) tick(0, 0, 64'h0, 1, 1);
    check("mid_v_before", s_v, 1);
    check("mid_pc_before", s_pc, 64'h400);
    tick(1, 0, 64'h0, 1, 1);
    tick(0, 0, 64'h0, 0, 1);
    check("mid_v_after", s_v, 0);
    check("mid_addr_after", s_addr, RPC);
    run_until_valid(20);
    check("mid_first_pc", s_pc, RPC);
    check("mid_first_in", s_instr, memf(RPC));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 4);
      tick(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 15) == 0),
           {$urandom, $urandom},
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues in-order requests to a pipelined instruction memory with variable latency.
- Buffers up to DEPTH fetched instructions with their PCs and presents them to IF/ID.
- Holds output under hazard stall; flushes all buffered and in-flight fetches on a taken-branch redirect from EX/MEM.

Parameters:
- DEPTH, 4, queue entries and max outstanding plus buffered fetches (power of 2, >=2).
- RESET_PC, 64'h0, fetch PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- redirect_valid  in  1  taken branch (Branch & zero from EX/MEM).
- redirect_pc  in  64  branch target from EX/MEM.
- stall  in  1  hazard-unit hold (inverse of PC/IF-ID write enable).
- imem_req  out  1  fetch request valid.
- imem_addr  out  64  fetch address.
- imem_gnt  in  1  memory accepts the request this cycle; ignored when imem_req=0.
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  response instruction.
- if_valid  out  1  head entry holds a complete instruction.
- if_pc  out  64  PC of head entry.
- if_instr  out  32  instruction of head entry.

Behaviour:
- Reset (synchronous, active-high):
  - queue empty; fetch_pc=RESET_PC; drop_cnt=0.
  - imem_req=0, if_valid=0, if_pc=0, if_instr=0.
  - imem_rvalid ignored during reset; the memory is reset by the same reset, so no stale responses remain.
- Queue: DEPTH-entry circular buffer with three pointers.
  - alloc_ptr: entry allocated at grant time; PC recorded, data pending.
  - fill_ptr: next pending entry to receive imem_rdata.
  - head_ptr: next entry to output.
  - occupancy = allocated entries (pending + filled), 0..DEPTH.
  - Pointers wrap modulo DEPTH.
- Request:
  - imem_req = !reset && !redirect_valid && occupancy < DEPTH, using registered occupancy (no same-cycle pop bypass).
  - imem_addr = fetch_pc.
  - On imem_req && imem_gnt: allocate the entry at alloc_ptr with pc=fetch_pc; fetch_pc <= fetch_pc+4 (wraps mod 2^64).
- Response, when imem_rvalid=1:
  - drop_cnt>0: discard the data; drop_cnt decrements.
  - otherwise: write imem_rdata into the entry at fill_ptr, mark it filled, advance fill_ptr.
  - A response with no pending entry and drop_cnt=0 is a protocol error; ignore it.
- Output:
  - if_valid=1 iff the head entry is allocated and filled.
  - if_pc and if_instr come combinationally from the head entry; both read 0 when if_valid=0.
  - Pop when if_valid && !stall; head_ptr advances at the clock edge.
  - Output is held stable while stall=1.
- Latency:
  - Grant at cycle t with rvalid at t+k gives if_valid at t+k+1.
  - With k=1 and no stall, sustained throughput is 1 instruction/cycle for DEPTH>=2.
- Simultaneous events:
  - Alloc, fill and pop may all occur in one cycle.
  - A fill and a pop of the same entry in one cycle cannot happen, because fill makes the entry visible only next cycle.
- Redirect (redirect_valid=1), which overrides stall and all other activity:
  - Next state: queue empty (all entries invalid, pointers 0).
  - fetch_pc <= {redirect_pc[63:2],2'b00}.
  - drop_cnt <= drop_cnt + pending_count − (imem_rvalid ? 1 : 0).
  - No pop this cycle; imem_req=0 this cycle; fetching resumes the next cycle.
  - drop_cnt saturates at DEPTH and never underflows.
  - A redirect while drop_cnt>0 accumulates correctly.
- Stall with a full queue: imem_req=0 until a pop frees an entry. In-flight responses always have a reserved entry, so none are lost.

Test Plan:
- Reset then run, 1-cycle memory, gnt=1, no stall:
  - imem_addr=0,4,8,...
  - if_valid first rises 2 cycles after reset release with if_pc=0.
  - One instruction per cycle thereafter; if_instr matches memory content.
- stall=1 for 6 cycles at if_pc=0x10:
  - if_pc/if_instr hold 0x10.
  - imem_req drops once occupancy=4 (last addr 0x1C).
  - Release: 0x10,0x14,0x18,0x1C output on consecutive cycles with no gaps.
- 3-cycle latency memory, redirect_pc=0x200 while 2 requests are pending:
  - the next 2 rvalid responses are discarded.
  - first output after redirect is if_pc=0x200 with the data for 0x200.
- redirect in the same cycle as imem_rvalid, 1 pending:
  - drop_cnt stays 0.
  - the next response (addr 0x200) is output.
- redirect_pc=0x203: fetch resumes at imem_addr=0x200.
- reset asserted mid-stream with 3 entries filled:
  - next cycle if_valid=0, imem_addr=RESET_PC.
  - no stale instruction ever appears on the output.
